mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port word memory (combinational read, write on posedge clk) between the core's instruction-fetch port and its load/store port.
- Each requester gets a valid/ready request channel and a valid/ready response channel; at most one transaction is outstanding.
- Arbitration is data-priority with a bounded-starvation guarantee for fetch.
- Sits between the core front-end/LSU and the memory instance.

Parameters:
- MEM_WORDS, 255, number of implemented 32-bit words; word index >= MEM_WORDS is out of range.
- MAX_STREAK, 4, max consecutive data grants while fetch is waiting (range 1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  32  fetch byte address
- if_rsp_valid  out  1  fetch response valid
- if_rsp_ready  in  1  fetch response consumed
- if_rsp_data  out  32  fetched word
- if_rsp_err  out  1  out-of-range access
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted
- d_addr  in  32  data byte address
- d_we  in  1  1 = store, 0 = load
- d_wdata  in  32  store data
- d_rsp_valid  out  1  data response valid
- d_rsp_ready  in  1  data response consumed
- d_rsp_data  out  32  load data; for stores, the pre-write word
- d_rsp_err  out  1  out-of-range access
- mem_address  out  32  to memory address
- mem_write_data  out  32  to memory write_data
- mem_write_enable  out  1  to memory write_enable
- mem_read_data  in  32  from memory read_data

Behaviour:
- States: IDLE and RESP. RESP carries an owner (FETCH or DATA).
- Reset values: state IDLE, all rsp_valid 0, rsp_data 0, rsp_err 0, streak 0, mem_write_enable 0.
- Accept condition: "can_accept" = state IDLE, or state RESP with the owner's rsp_ready = 1 (the response retires this cycle). Back-to-back throughput is one transaction per cycle.
- Arbitration (only when can_accept):
  - If only one valid is high, that requester wins.
  - If both are high, DATA wins unless streak == MAX_STREAK, in which case FETCH wins.
  - Exactly one of if_req_ready / d_req_ready is high, for the winner only; neither is high when not can_accept.
- Grant cycle (combinational outputs):
  - mem_address = winner's address with bits [1:0] forced to 0.
  - mem_write_data = d_wdata.
  - mem_write_enable = (winner is DATA) & d_we & in_range.
  - in_range = (addr[31:2] < MEM_WORDS).
- Grant posedge:
  - rsp_data <= in_range ? mem_read_data : 0. This is the pre-write value.
  - rsp_err <= !in_range.
  - state <= RESP with owner = winner.
  - Latency: response is visible the cycle after acceptance.
- Retire without a new grant: state <= IDLE and rsp_valid drops.
- Response hold: while rsp_valid is high and rsp_ready is low, rsp_data and rsp_err are held stable and no new request is accepted.
- Idle memory outputs: when there is no grant, mem_write_enable = 0, and mem_address/mem_write_data are don't-care and driven to 0.
- Streak counter:
  - +1 on a DATA grant while if_req_valid is high.
  - Cleared on any FETCH grant, or in any cycle where if_req_valid is low.
  - Saturates at MAX_STREAK.
- Misaligned addresses: bits [1:0] are ignored silently; no error is raised.
- Reset mid-operation: the pending response is dropped and valid is cleared. A store granted in the same cycle as rst = 1 is not performed, because mem_write_enable is gated by !rst.
- Out of range: a store is suppressed (no write), and the response returns err = 1 with data 0.

Decomposition:
- Shared package (riscv_structures): enum arb_owner_e {OWNER_FETCH, OWNER_DATA}, enum arb_state_e {ARB_IDLE, ARB_RESP}, constant ARB_WORD_SHIFT = 2.
- One sub-module: arb_priority_select (combinational).
  - Inputs: if_valid, d_valid, streak_full.
  - Outputs: grant_fetch, grant_data.
  - Unit-tested separately.
- FSM, streak counter and response registers stay in mem_port_arbiter.

Test Plan:
- Fetch-only read, mem word 75 = 0xDEADBEEF: if_addr = 0x12C, if_req_valid for 1 cycle, if_rsp_ready = 1 -> if_req_ready in cycle 0; if_rsp_valid in cycle 1 with data 0xDEADBEEF, err = 0; mem_write_enable never high.
- Store then load: d_we = 1, d_addr = 0x1A4 (word 105, 0xFFFFFFFF), d_wdata = 0x11223344, then a load of the same address -> first rsp_data = 0xFFFFFFFF; second rsp_data = 0x11223344; accepts in consecutive cycles.
- Contention, MAX_STREAK = 4: both valids held high continuously, rsp_ready = 1 -> grant pattern DATA×4, FETCH, DATA×4, FETCH…
- Backpressure: d_rsp_ready = 0 for 3 cycles after a load of word 95 (0x5) with a fetch pending -> d_rsp_valid and data 0x5 stable for 3 cycles; if_req_ready = 0 throughout; fetch granted in the cycle d_rsp_ready rises.
- Out of range: d_addr = 0x3FC (word 255), store of 0xAAAAAAAA -> mem_write_enable = 0, d_rsp_err = 1, d_rsp_data = 0; a subsequent read of word 254 is unchanged.
- Reset mid-response: rst = 1 while d_rsp_valid = 1 and a store is requested -> next cycle all rsp_valid = 0 and state IDLE; the target word is unchanged.

Source files
------------

// File: rtl/riscv_structures.sv
// Shared types and helpers for the memory port arbiter.
package riscv_structures;

    typedef enum logic {OWNER_FETCH, OWNER_DATA} arb_owner_e;
    typedef enum logic {ARB_IDLE, ARB_RESP} arb_state_e;

    localparam int ARB_WORD_SHIFT = 2;

    // True when the byte address names an implemented word.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned words);
        return (addr >> ARB_WORD_SHIFT) < words;
    endfunction

endpackage

// File: rtl/arb_priority_select.sv
// Two-requester priority pick: data first, fetch once the data streak is spent.
module arb_priority_select (
    input  logic if_valid,
    input  logic d_valid,
    input  logic streak_full,
    output logic grant_fetch,
    output logic grant_data
);

    // Fetch wins alone or when data has used up its streak budget.
    always_comb begin
        grant_fetch = if_valid & (~d_valid | streak_full);
        grant_data  = d_valid & (~if_valid | ~streak_full);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between the fetch and load/store ports.
// One transaction outstanding; a retiring response frees the slot in the same
// cycle so back-to-back transactions run at one per cycle.
module mem_port_arbiter
    import riscv_structures::*;
#(
    parameter int MEM_WORDS  = 255,
    parameter int MAX_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_rsp_valid,
    input  logic        if_rsp_ready,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [31:0] d_wdata,
    output logic        d_rsp_valid,
    input  logic        d_rsp_ready,
    output logic [31:0] d_rsp_data,
    output logic        d_rsp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);

    localparam logic [3:0]  STREAK_MAX = 4'(MAX_STREAK);
    localparam logic [31:0] WORD_MASK  = ~32'h3;

    arb_state_e  state_q, state_d;
    arb_owner_e  owner_q, owner_d;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;
    logic [3:0]  streak_q;

    logic        retire, can_accept;
    logic        grant_fetch, grant_data, grant;
    logic [31:0] sel_addr;
    logic        in_range;

    arb_priority_select u_sel (
        .if_valid    (if_req_valid & can_accept),
        .d_valid     (d_req_valid & can_accept),
        .streak_full (streak_q == STREAK_MAX),
        .grant_fetch (grant_fetch),
        .grant_data  (grant_data)
    );

    assign grant    = grant_fetch | grant_data;
    assign sel_addr = grant_data ? d_addr : if_addr;
    assign in_range = addr_in_range(sel_addr, MEM_WORDS);

    assign if_req_ready = grant_fetch;
    assign d_req_ready  = grant_data;
    assign if_rsp_valid = (state_q == ARB_RESP) && (owner_q == OWNER_FETCH);
    assign d_rsp_valid  = (state_q == ARB_RESP) && (owner_q == OWNER_DATA);
    assign if_rsp_data  = rsp_data_q;
    assign d_rsp_data   = rsp_data_q;
    assign if_rsp_err   = rsp_err_q;
    assign d_rsp_err    = rsp_err_q;

    // Next state: a grant always (re)enters RESP; a bare retire returns to IDLE.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        retire     = (state_q == ARB_RESP) &&
                     (owner_q == OWNER_FETCH ? if_rsp_ready : d_rsp_ready);
        can_accept = (state_q == ARB_IDLE) || retire;
        if (grant) begin
            state_d = ARB_RESP;
            owner_d = grant_data ? OWNER_DATA : OWNER_FETCH;
        end else if (retire) begin
            state_d = ARB_IDLE;
        end
    end

    // Memory drive: only during a grant; stores out of range or under reset are dropped.
    always_comb begin
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_enable = 1'b0;
        if (grant) begin
            mem_address      = sel_addr & WORD_MASK;
            mem_write_data   = d_wdata;
            mem_write_enable = grant_data & d_we & in_range & ~rst;
        end
    end

    // State and owner register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= OWNER_FETCH;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Capture the pre-write word at grant; hold it until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else if (grant) begin
            rsp_data_q <= in_range ? mem_read_data : 32'h0;
            rsp_err_q  <= ~in_range;
        end
    end

    // Count data grants that passed over a waiting fetch.
    always_ff @(posedge clk) begin
        if (rst || !if_req_valid || grant_fetch) begin
            streak_q <= '0;
        end else if (grant_data && streak_q != STREAK_MAX) begin
            streak_q <= streak_q + 4'd1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int MEM_WORDS  = 255;
    localparam int MAX_STREAK = 4;

    logic        clk;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready, if_rsp_err;
    logic [31:0] if_addr, if_rsp_data;
    logic        d_req_valid, d_req_ready, d_we, d_rsp_valid, d_rsp_ready, d_rsp_err;
    logic [31:0] d_addr, d_wdata, d_rsp_data;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_write_enable;

    int vectors    = 0;
    int miscompares = 0;

    // Memory model: combinational read, posedge write, plus a preload port.
    logic [31:0] mem [0:MEM_WORDS-1];
    logic        pk_en;
    logic [7:0]  pk_idx;
    logic [31:0] pk_val;
    logic [31:0] ref_mem [0:MEM_WORDS-1];

    wire         mem_hit = (mem_address >> 2) < MEM_WORDS;
    wire  [7:0]  mem_idx = mem_address[9:2];

    assign mem_read_data = mem_hit ? mem[mem_idx] : 32'hBAD0BAD0;

    always @(posedge clk) begin
        if (pk_en) mem[pk_idx] <= pk_val;
        else if (mem_write_enable && mem_hit) mem[mem_idx] <= mem_write_data;
    end

    mem_port_arbiter #(.MEM_WORDS(MEM_WORDS), .MAX_STREAK(MAX_STREAK)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready),
        .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_we(d_we), .d_wdata(d_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready),
        .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        if_req_valid = 0; if_addr = 0; if_rsp_ready = 1;
        d_req_valid = 0; d_addr = 0; d_we = 0; d_wdata = 0; d_rsp_ready = 1;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic poke(input int idx, input logic [31:0] v);
        pk_en = 1; pk_idx = 8'(idx); pk_val = v;
        tick();
        pk_en = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        #1;
        vectors++; if (if_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_if_valid: got %b exp 0", if_rsp_valid); end
        vectors++; if (d_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_d_valid: got %b exp 0", d_rsp_valid); end
        vectors++; if (d_rsp_data !== 32'h0 || d_rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp: got %h/%b exp 0/0", d_rsp_data, d_rsp_err); end
        vectors++; if (mem_write_enable !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b exp 0", mem_write_enable); end
    endtask

    task automatic test_fetch_read;
        do_reset();
        poke(75, 32'hDEADBEEF);
        if_addr = 32'h12C; if_req_valid = 1;
        #1;
        vectors++; if (if_req_ready !== 1'b1 || d_req_ready !== 1'b0) begin miscompares++; $display("FAIL fetch_ready: got %b%b exp 10", if_req_ready, d_req_ready); end
        vectors++; if (mem_address !== 32'h12C || mem_write_enable !== 1'b0) begin miscompares++; $display("FAIL fetch_mem: got %h/%b exp 0000012c/0", mem_address, mem_write_enable); end
        tick();
        if_req_valid = 0;
        #1;
        vectors++; if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'hDEADBEEF || if_rsp_err !== 1'b0) begin miscompares++; $display("FAIL fetch_rsp: got %b %h %b exp 1 deadbeef 0", if_rsp_valid, if_rsp_data, if_rsp_err); end
        vectors++; if (mem_write_enable !== 1'b0) begin miscompares++; $display("FAIL fetch_we: got %b exp 0", mem_write_enable); end
        tick();
        vectors++; if (if_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL fetch_retire: got %b exp 0", if_rsp_valid); end
    endtask

    task automatic test_store_load;
        do_reset();
        poke(105, 32'hFFFFFFFF);
        d_req_valid = 1; d_we = 1; d_addr = 32'h1A4; d_wdata = 32'h11223344;
        #1;
        vectors++; if (d_req_ready !== 1'b1 || mem_write_enable !== 1'b1) begin miscompares++; $display("FAIL store_grant: got %b/%b exp 1/1", d_req_ready, mem_write_enable); end
        tick();
        d_we = 0;
        #1;
        vectors++; if (d_req_ready !== 1'b1) begin miscompares++; $display("FAIL load_b2b_ready: got %b exp 1", d_req_ready); end
        vectors++; if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL store_rsp: got %b %h exp 1 ffffffff", d_rsp_valid, d_rsp_data); end
        tick();
        d_req_valid = 0;
        #1;
        vectors++; if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'h11223344) begin miscompares++; $display("FAIL load_rsp: got %b %h exp 1 11223344", d_rsp_valid, d_rsp_data); end
        tick();
    endtask

    task automatic test_contention;
        logic exp_f;
        do_reset();
        if_req_valid = 1; if_addr = 32'h10;
        d_req_valid = 1; d_addr = 32'h20; d_we = 0;
        for (int i = 0; i < 15; i++) begin
            #1;
            exp_f = (i % (MAX_STREAK + 1)) == MAX_STREAK;
            vectors++;
            if (if_req_ready !== exp_f || d_req_ready !== !exp_f) begin
                miscompares++;
                $display("FAIL contention_%0d: got if=%b d=%b exp if=%b", i, if_req_ready, d_req_ready, exp_f);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_backpressure;
        do_reset();
        poke(95, 32'h5);
        d_req_valid = 1; d_addr = 32'h17C; d_we = 0; d_rsp_ready = 0;
        if_req_valid = 1; if_addr = 32'h0;
        #1;
        vectors++; if (d_req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_grant: got %b exp 1", d_req_ready); end
        tick();
        d_req_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'h5 || if_req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold_%0d: got v=%b data=%h if_rdy=%b exp 1 5 0", i, d_rsp_valid, d_rsp_data, if_req_ready);
            end
            tick();
        end
        d_rsp_ready = 1;
        #1;
        vectors++; if (if_req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release: got %b exp 1", if_req_ready); end
        tick();
        if_req_valid = 0;
        #1;
        vectors++; if (if_rsp_valid !== 1'b1 || d_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_after: got if=%b d=%b exp 1 0", if_rsp_valid, d_rsp_valid); end
        tick();
    endtask

    task automatic test_out_of_range;
        do_reset();
        poke(254, 32'h12345678);
        d_req_valid = 1; d_we = 1; d_addr = 32'h3FC; d_wdata = 32'hAAAAAAAA;
        #1;
        vectors++; if (d_req_ready !== 1'b1 || mem_write_enable !== 1'b0) begin miscompares++; $display("FAIL oor_we: got rdy=%b we=%b exp 1 0", d_req_ready, mem_write_enable); end
        tick();
        d_we = 0; d_addr = 32'h3F8;
        #1;
        vectors++; if (d_rsp_err !== 1'b1 || d_rsp_data !== 32'h0) begin miscompares++; $display("FAIL oor_rsp: got %b %h exp 1 0", d_rsp_err, d_rsp_data); end
        tick();
        d_req_valid = 0;
        #1;
        vectors++; if (d_rsp_err !== 1'b0 || d_rsp_data !== 32'h12345678) begin miscompares++; $display("FAIL oor_neighbour: got %b %h exp 0 12345678", d_rsp_err, d_rsp_data); end
        tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        poke(20, 32'h0A0A0A0A);
        d_req_valid = 1; d_addr = 32'h28; d_we = 0; d_rsp_ready = 0;
        tick();
        d_rsp_ready = 1; d_we = 1; d_addr = 32'h50; d_wdata = 32'h55555555;
        rst = 1;
        #1;
        vectors++; if (mem_write_enable !== 1'b0) begin miscompares++; $display("FAIL rstmid_we: got %b exp 0", mem_write_enable); end
        tick();
        rst = 0; d_req_valid = 0; d_we = 0;
        #1;
        vectors++; if (d_rsp_valid !== 1'b0 || if_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid: got if=%b d=%b exp 0 0", if_rsp_valid, d_rsp_valid); end
        vectors++; if (mem[20] !== 32'h0A0A0A0A) begin miscompares++; $display("FAIL rstmid_mem: got %h exp 0a0a0a0a", mem[20]); end
        tick();
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r, w;
        r = $urandom_range(0, 9);
        if (r == 0) return $urandom;
        if (r == 1) w = 255 + $urandom_range(0, 10);
        else if (r < 6) w = $urandom_range(0, 7);
        else w = $urandom_range(0, 254);
        return (w << 2) | $urandom_range(0, 3);
    endfunction

    task automatic test_random;
        bit pend, pf, perr, retire, free, gf, gd, ew, inr;
        bit ifv, dv, we, ifrr, drr, r;
        logic [31:0] ia, da, wd, pdata, ea, ed;
        int unsigned w;
        int streak;
        do_reset();
        for (int i = 0; i < MEM_WORDS; i++) begin
            ref_mem[i] = $urandom;
            poke(i, ref_mem[i]);
        end
        pend = 0; pf = 0; perr = 0; pdata = 0; streak = 0;
        for (int n = 0; n < 3000; n++) begin
            vectors++;
            if (if_rsp_valid !== (pend && pf) || d_rsp_valid !== (pend && !pf)) begin
                miscompares++;
                $display("FAIL rnd_valid_%0d: got if=%b d=%b exp if=%b d=%b", n, if_rsp_valid, d_rsp_valid, pend && pf, pend && !pf);
            end
            if (pend) begin
                vectors++;
                if ((pf ? if_rsp_data : d_rsp_data) !== pdata || (pf ? if_rsp_err : d_rsp_err) !== perr) begin
                    miscompares++;
                    $display("FAIL rnd_rsp_%0d: got %h/%b exp %h/%b", n, pf ? if_rsp_data : d_rsp_data, pf ? if_rsp_err : d_rsp_err, pdata, perr);
                end
            end
            ifv = $urandom_range(0, 9) < 6; dv = $urandom_range(0, 9) < 6;
            we = $urandom_range(0, 1) == 1; ifrr = $urandom_range(0, 9) < 7;
            drr = $urandom_range(0, 9) < 7; r = $urandom_range(0, 99) == 0;
            ia = rand_addr(); da = rand_addr(); wd = $urandom;
            if_req_valid = ifv; if_addr = ia; if_rsp_ready = ifrr;
            d_req_valid = dv; d_addr = da; d_we = we; d_wdata = wd; d_rsp_ready = drr;
            rst = r;
            #1;
            retire = pend && (pf ? ifrr : drr);
            free = !pend || retire;
            gf = 0; gd = 0;
            if (free) begin
                if (ifv && dv) begin
                    if (streak == MAX_STREAK) gf = 1; else gd = 1;
                end else begin
                    gf = ifv; gd = dv;
                end
            end
            w = gf ? (ia >> 2) : (da >> 2);
            inr = w < MEM_WORDS;
            ea = gf ? (ia & ~32'h3) : gd ? (da & ~32'h3) : 32'h0;
            ed = (gf || gd) ? wd : 32'h0;
            ew = gd && we && inr && !r;
            if (!r) begin
                vectors++;
                if (if_req_ready !== gf || d_req_ready !== gd) begin
                    miscompares++;
                    $display("FAIL rnd_ready_%0d: got if=%b d=%b exp if=%b d=%b", n, if_req_ready, d_req_ready, gf, gd);
                end
            end
            vectors++;
            if (mem_write_enable !== ew || mem_address !== ea || mem_write_data !== ed) begin
                miscompares++;
                $display("FAIL rnd_mem_%0d: got we=%b a=%h d=%h exp we=%b a=%h d=%h", n, mem_write_enable, mem_address, mem_write_data, ew, ea, ed);
            end
            if (r) begin
                pend = 0; streak = 0;
            end else begin
                if (gf || gd) begin
                    pend = 1; pf = gf;
                    pdata = inr ? ref_mem[w] : 32'h0;
                    perr = !inr;
                    if (ew) ref_mem[w] = wd;
                end else if (retire) begin
                    pend = 0;
                end
                if (!ifv || gf) streak = 0;
                else if (gd && streak < MAX_STREAK) streak++;
            end
            tick();
        end
        rst = 0;
        idle_inputs();
        tick();
    endtask

    initial begin
        pk_en = 0; pk_idx = 0; pk_val = 0;
        rst = 1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_fetch_read();
        test_store_load();
        test_contention();
        test_backpressure();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
